// File: rtl/alu_muldiv.sv
// RV32I/RV64I integer execute unit: one-cycle ALU, fixed-latency multiply and a
// one-bit-per-cycle restoring divider, all behind a valid/ready handshake.
module alu_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            use_imm,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   MUL_LAST = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]      f3_q, f3_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept, is_mop;
  logic [XLEN-1:0] b_sel;

  assign in_ready  = rst_n && !flush &&
                     ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign b_sel     = use_imm ? imm : operand_b;
  assign is_mop    = !use_imm && (funct7 == 7'b0000001);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;

  // Multiplier operands are the live inputs on the accept cycle, the captured copy afterwards.
  always_comb begin
    op_a_d = accept ? operand_a : op_a_q;
    op_b_d = accept ? b_sel : op_b_q;
    f3_d   = accept ? funct3[1:0] : f3_q;
  end

  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  always_comb begin
    shamt   = b_sel[SHW-1:0];
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (!use_imm && funct7[5]) ? operand_a - b_sel : operand_a + b_sel;
      3'b001:  alu_res = operand_a << shamt;
      3'b010:  alu_res = XLEN'($signed(operand_a) < $signed(b_sel));
      3'b011:  alu_res = XLEN'(operand_a < b_sel);
      3'b100:  alu_res = operand_a ^ b_sel;
      3'b101:  alu_res = funct7[5] ? $unsigned($signed(operand_a) >>> shamt) : operand_a >> shamt;
      3'b110:  alu_res = operand_a | b_sel;
      default: alu_res = operand_a & b_sel;
    endcase
    if (!use_imm && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
      alu_res = '0;
  end

  // Sign-extending each operand to 2*XLEN gives the exact low 2*XLEN product bits
  // for every signed/unsigned pairing.
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;
  always_comb begin
    mul_sa  = (f3_d != 2'b11) && op_a_d[XLEN-1];
    mul_sb  = (f3_d == 2'b01) && op_b_d[XLEN-1];
    prod    = {{XLEN{mul_sa}}, op_a_d} * {{XLEN{mul_sb}}, op_b_d};
    mul_res = (f3_d == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  logic            div_signed, a_neg, b_neg, div_by_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res, quo_next, rem_next, div_res;
  logic [XLEN:0]   trial, diff;
  always_comb begin
    div_signed  = !funct3[0];
    a_neg       = div_signed && operand_a[XLEN-1];
    b_neg       = div_signed && b_sel[XLEN-1];
    a_mag       = a_neg ? -operand_a : operand_a;
    b_mag       = b_neg ? -b_sel : b_sel;
    div_by_zero = (b_sel == '0);
    div_ovf     = div_signed && (operand_a == MOST_NEG) && (b_sel == '1);
    if (div_by_zero) fast_res = funct3[1] ? operand_a : '1;
    else             fast_res = funct3[1] ? '0 : MOST_NEG;
    // Partial remainder needs one extra bit before the trial subtraction.
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end
    if (f3_q[1]) div_res = neg_rem_q ? -rem_next : rem_next;
    else         div_res = neg_quo_q ? -quo_next : quo_next;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d   = state_q;
    result_d  = result_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          state_d  = S_DONE;
          result_d = div_res;
        end
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      cnt_d = '0;
      if (is_mop && !funct3[2]) begin
        if (MUL_STAGES > 1) begin
          state_d = S_MUL;
        end else begin
          state_d  = S_DONE;
          result_d = mul_res;
        end
      end else if (is_mop && (div_by_zero || div_ovf)) begin
        state_d  = S_DONE;
        result_d = fast_res;
      end else if (is_mop) begin
        state_d   = S_DIV;
        quo_d     = a_mag;
        rem_d     = '0;
        dvs_d     = b_mag;
        neg_quo_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
      end else begin
        state_d  = S_DONE;
        result_d = alu_res;
      end
    end
    if (flush) state_d = S_IDLE;
  end

  // NOTE: the register block only copies _d to _q with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      f3_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      f3_q      <= f3_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (XLEN=32, MUL_STAGES=2): directed literal cases plus
// randomised traffic checked every cycle against a transaction-level model.
module tb_alu_muldiv;
  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 2;
  localparam int DIV_LAT    = XLEN + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, use_imm = 1'b0, out_ready = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] operand_a = '0, operand_b = '0, imm = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .use_imm(use_imm), .funct3(funct3), .funct7(funct7), .operand_a(operand_a),
    .operand_b(operand_b), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics straight from the ISA rules, using 64-bit arithmetic.
  function automatic void ref_op(input logic ui, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                 output logic [31:0] res, output int lat);
    logic [31:0] bb;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    bb  = ui ? im : b;
    sa  = longint'($signed(a));
    sb  = longint'($signed(bb));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, bb});
    res = '0;
    lat = 1;
    if (!ui && f7 == 7'h01) begin
      case (f3)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          lat = MUL_STAGES;
          case (f3)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            default:    p = ua * ub;
          endcase
          res = (f3 == 3'd0) ? p[31:0] : p[63:32];
        end
        3'd4, 3'd6: begin
          if (bb == 0) res = (f3 == 3'd4) ? 32'hFFFF_FFFF : a;
          else if (a == 32'h8000_0000 && bb == 32'hFFFF_FFFF) res = (f3 == 3'd4) ? a : 32'h0;
          else begin
            lat = DIV_LAT;
            res = (f3 == 3'd4) ? 32'(sa / sb) : 32'(sa % sb);
          end
        end
        default: begin
          if (bb == 0) res = (f3 == 3'd5) ? 32'hFFFF_FFFF : a;
          else begin
            lat = DIV_LAT;
            res = (f3 == 3'd5) ? 32'(ua / ub) : 32'(ua % ub);
          end
        end
      endcase
    end else if (!ui && f7 != 7'h00 && f7 != 7'h20) begin
      res = '0;
    end else begin
      case (f3)
        3'd0:    res = (!ui && f7[5]) ? a - bb : a + bb;
        3'd1:    res = a << bb[4:0];
        3'd2:    res = {31'b0, sa < sb};
        3'd3:    res = {31'b0, ua < ub};
        3'd4:    res = a ^ bb;
        3'd5:    res = f7[5] ? 32'(sa >>> bb[4:0]) : a >> bb[4:0];
        3'd6:    res = a | bb;
        default: res = a & bb;
      endcase
    end
  endfunction

  // Model: a pending result with a remaining-cycle countdown, and a held output.
  logic        m_valid  = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pres   = '0;
  int          m_pend   = 0;

  function automatic logic m_in_ready();
    return rst_n && !flush && ((!m_valid && m_pend == 0) || (m_valid && out_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_result <= '0;
      m_pend   <= 0;
    end else begin : model_step
      logic        v, acc;
      logic [31:0] res, pres, r;
      int          pend, l;
      v    = m_valid;
      res  = m_result;
      pres = m_pres;
      pend = m_pend;
      acc  = in_valid && m_in_ready();
      if (flush) begin
        v    = 1'b0;
        pend = 0;
      end else begin
        if (v && out_ready) v = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            v   = 1'b1;
            res = pres;
          end
        end
        if (acc) begin
          ref_op(use_imm, funct3, funct7, operand_a, operand_b, imm, r, l);
          if (l == 1) begin
            v   = 1'b1;
            res = r;
          end else begin
            pend = l - 1;
            pres = r;
          end
        end
      end
      m_valid  <= v;
      m_result <= res;
      m_pres   <= pres;
      m_pend   <= pend;
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_pend > 0));
    check("in_ready", 32'(in_ready), 32'(m_in_ready()));
    if (!rst_n || m_valid) check("result", result, m_result);
  end

  task automatic run_op(input string name, input logic ui, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] exp_res, input int exp_lat,
                        output int busy_cyc, output int nready_cyc);
    int waitc, lat;
    busy_cyc   = 0;
    nready_cyc = 0;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; use_imm = ui; funct3 = f3; funct7 = f7;
    operand_a = a; operand_b = b; imm = im;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check({name, " accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    operand_a = $urandom; operand_b = $urandom; imm = $urandom;
    funct3    = 3'($urandom); funct7 = 7'($urandom); use_imm = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (busy) busy_cyc++;
      if (!in_ready) nready_cyc++;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " value"}, result, exp_res);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int bc, nc, seen;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("SUB",    0, 3'd0, 7'h20, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 1, bc, nc);
    run_op("SRA",    0, 3'd5, 7'h20, 32'h8000_0000, 32'h4, 0, 32'hF800_0000, 1, bc, nc);
    run_op("SLT",    0, 3'd2, 7'h00, 32'h8000_0000, 32'h1, 0, 32'h1, 1, bc, nc);
    run_op("SLTU",   0, 3'd3, 7'h00, 32'h8000_0000, 32'h1, 0, 32'h0, 1, bc, nc);
    run_op("ADDI",   1, 3'd0, 7'h20, 32'd10, 32'hDEAD, 32'hFFFF_FFFD, 32'd7, 1, bc, nc);
    run_op("SLTIU",  1, 3'd3, 7'h00, 32'd5, 32'h0, 32'hFFFF_FFFF, 32'h1, 1, bc, nc);
    run_op("SRAI",   1, 3'd5, 7'h20, 32'h8000_0000, 32'h0, 32'd8, 32'hFF80_0000, 1, bc, nc);
    run_op("BADF7",  0, 3'd0, 7'h05, 32'd3, 32'd4, 0, 32'h0, 1, bc, nc);
    run_op("MULHU",  0, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'h2, 0, 32'h1, 2, bc, nc);
    check("MULHU busy cycles", 32'(bc), 32'd1);
    run_op("MULH",   0, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'h2, 0, 32'hFFFF_FFFF, 2, bc, nc);
    run_op("MULHSU", 0, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'h2, 0, 32'hFFFF_FFFF, 2, bc, nc);
    run_op("MUL",    0, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'h2, 0, 32'hFFFF_FFFE, 2, bc, nc);
    run_op("DIV",    0, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFD, 33, bc, nc);
    check("DIV in_ready low cycles", 32'(nc), 32'd32);
    check("DIV busy cycles", 32'(bc), 32'd32);
    run_op("REM",    0, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFF, 33, bc, nc);
    run_op("DIVU",   0, 3'd5, 7'h01, 32'd100, 32'd7, 0, 32'd14, 33, bc, nc);
    run_op("REMU",   0, 3'd7, 7'h01, 32'd100, 32'd7, 0, 32'd2, 33, bc, nc);
    run_op("DIVNEGB", 0, 3'd4, 7'h01, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 33, bc, nc);
    run_op("REMNEGB", 0, 3'd6, 7'h01, 32'd7, 32'hFFFF_FFFE, 0, 32'h1, 33, bc, nc);
    run_op("DIV0",   0, 3'd4, 7'h01, 32'd1234, 32'h0, 0, 32'hFFFF_FFFF, 1, bc, nc);
    run_op("REMU0",  0, 3'd7, 7'h01, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 1, bc, nc);
    run_op("DIVOVF", 0, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, bc, nc);
    run_op("REMOVF", 0, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 1, bc, nc);

    // Backpressure: hold an ADD result, then release with the next op waiting.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; use_imm = 1'b0; funct3 = 3'd0; funct7 = 7'h00;
    operand_a = 32'd5; operand_b = 32'd6;
    @(posedge clk); #1;
    funct3 = 3'd4; operand_a = 32'hF0F0_0000; operand_b = 32'h0F0F_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall result", result, 32'd11);
      check("stall in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post-stall XOR valid", 32'(out_valid), 32'd1);
    check("post-stall XOR", result, 32'hFFFF_FFFF);

    // Flush during cycle 10 of a divide.
    @(posedge clk); #1;
    in_valid = 1'b1; use_imm = 1'b0; funct3 = 3'd4; funct7 = 7'h01;
    operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("div started busy", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'd0; funct7 = 7'h00; operand_a = 1; operand_b = 1;
    @(negedge clk);
    check("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    check("flush out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no result", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    in_valid = 1'b1; funct3 = 3'd4; funct7 = 7'h01; operand_a = 32'd1000; operand_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset in_ready", 32'(in_ready), 32'd0);
    check("async reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b1; use_imm = 1'b0; funct3 = 3'd0; funct7 = 7'h00;
    operand_a = 32'd3; operand_b = 32'd4;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post-reset ADD valid", 32'(out_valid), 32'd1);
    check("post-reset ADD", result, 32'd7);

    // Random traffic; the per-cycle compare process does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(3) != 0);
      use_imm  = ($urandom_range(3) == 0);
      funct3   = 3'($urandom);
      case ($urandom_range(7))
        0, 1, 2: funct7 = 7'h01;
        3, 4:    funct7 = 7'h00;
        5:       funct7 = 7'h20;
        default: funct7 = 7'($urandom);
      endcase
      operand_a = rand_val();
      operand_b = rand_val();
      imm       = rand_val();
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(60) == 0);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
